moving_sum_win: RTL
===================

# moving_sum_win

Parametrised sliding-window accumulator for the OFDM 802.11 receiver front end (packet detection / auto-correlation energy path). It keeps its own window delay line, so callers supply only the new sample, not a pre-delayed copy. It maintains the exact sum of the last N accepted samples with a valid handshake, a window-full flag, a synchronous clear, and a power-of-two average output. Instances sit after the correlator and energy multipliers and feed the plateau/threshold detector.

## Interface
- DW, 17, input sample width
- WIN_LOG2, 4, log2 of window length; N = 2^WIN_LOG2, legal range 1..8
- SIGNED_IN, 0, 1 = samples are two's-complement, 0 = unsigned
- SW (derived, localparam), DW+WIN_LOG2+1, signed width of sum_out
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- clr  input  1  synchronous window clear
- in_valid  input  1  sample strobe
- in_data  input  DW  new sample
- out_valid  output  1  sum_out/avg_out updated this cycle
- sum_out  output  SW  signed sum of the last min(fill, N) samples
- avg_out  output  DW+1  signed, sum_out arithmetically shifted right by WIN_LOG2
- full  output  1  window holds N samples

## Operation
- Extension: in_data is sign-extended to SW when SIGNED_IN=1 and zero-extended when SIGNED_IN=0. All internal arithmetic is signed, SW bits wide, and never overflows.
- Delay line: N-entry circular buffer with write pointer wp, wrapping modulo N.
- Fill counter: fill counts 0..N and saturates at N.
- On an accepted sample (in_valid=1, clr=0):
  - old = buf[wp] if fill==N, else 0. Entries are never cleared; fill masks stale contents.
  - buf[wp] <= in_data; wp <= wp+1.
  - sum <= sum + ext(in_data) − ext(old).
  - fill <= min(fill+1, N).
- in_valid=0, clr=0: all state holds; out_valid=0.
- clr=1, in_valid=0: sum, fill and wp go to 0; out_valid=0.
- clr=1 and in_valid=1 in the same cycle: state is cleared, then this sample is taken as the first sample of the new window. Result: sum=ext(in_data), fill=1, wp=1, buf[0]=in_data, out_valid=1.
- full = (fill==N), registered alongside sum.
- avg_out = sum_out >>> WIN_LOG2, truncating toward −∞.

## Timing
- Latency is 1 cycle: a sample accepted at edge t appears in sum_out with out_valid=1 after edge t. sum_out is registered, not combinational.
- Throughput is 1 sample per cycle. There is no backpressure; every in_valid is accepted.
- sum_out, avg_out and full hold their values between valid strobes.
- Reset values: out_valid=0, sum_out=0, avg_out=0, full=0; internally wp=0, fill=0. Buffer contents are don't-care.
- Reset mid-window discards the window. The first sample after reset yields sum=ext(sample), full=0.
- full asserts in the cycle out_valid carries the N-th sample after reset or clear.
- rst takes priority over clr, and clr over in_valid (with the merged behaviour above).

## Structure
- Shared package ofdm_rx_pkg holds the width helper function (sum width = DW+WIN_LOG2+1) and the legal WIN_LOG2 bounds, checked at elaboration.
- One sub-module, win_delay_line: parameters DW and WIN_LOG2; ports clk, we, wp, din, dout (read of buf[wp] before the write). Implemented as a register array, inferable as distributed RAM.
- Top level holds fill/wp control, extension, adder/subtractor and output registers.

## Test plan
- Fill, unsigned (DW=17, WIN_LOG2=2, SIGNED_IN=0): samples 1,2,3,4,5,6 -> sums 1,3,6,10,14,18; full rises with the 4th sample; avg_out for the 6th sample = 4.
- Full-scale unsigned: 8 × 17'h1FFFF with N=4 -> sum_out=524284 (0x7FFFC), no wrap, avg_out=131071.
- Signed (SIGNED_IN=1, N=4): samples −5,3,−7,2,−1 -> sums −5,−2,−9,−7,−3; avg_out for the last sample = −1.
- Gaps: valid pattern 1,0,0,1,1 with data 10,x,x,20,30 -> out_valid pulses only on accepted cycles, sums 10,30,60; outputs hold during gaps.
- Clear: after full window {4,4,4,4} (sum 16), assert clr with in_valid and data 7 -> sum 7, full=0. Then 1 -> sum 8. Then clr alone -> sum 0, out_valid=0.
- Reset mid-window: rst after 3 samples -> all outputs 0 next cycle. The next sample 9 gives sum 9, full=0, and no stale buffer contribution after N further samples.

Source files
------------

// File: rtl/moving_sum_win_pkg.sv
// rtl/moving_sum_win_pkg.sv - shared OFDM receiver widths and window bounds
package ofdm_rx_pkg;

  localparam int WIN_LOG2_MIN = 1;
  localparam int WIN_LOG2_MAX = 8;

  // One guard bit above DW+WIN_LOG2 keeps the signed sum of N samples exact.
  function automatic int sum_width(input int dw, input int win_log2);
    return dw + win_log2 + 1;
  endfunction

endpackage

// File: rtl/moving_sum_win_if.sv
// rtl/moving_sum_win_if.sv - sample-in / window-sum-out bundle for moving_sum_win
interface moving_sum_win_if
  import ofdm_rx_pkg::*;
#(
  parameter int DW       = 17,
  parameter int WIN_LOG2 = 4
);
  localparam int SW = sum_width(DW, WIN_LOG2);

  logic                 clr;
  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 out_valid;
  logic signed [SW-1:0] sum_out;
  logic signed [DW:0]   avg_out;
  logic                 full;

  modport master (
    output clr, in_valid, in_data,
    input  out_valid, sum_out, avg_out, full
  );

  modport slave (
    input  clr, in_valid, in_data,
    output out_valid, sum_out, avg_out, full
  );

endinterface

// File: rtl/moving_sum_win_delay_line.sv
// rtl/moving_sum_win_delay_line.sv - N-entry circular sample buffer, read-before-write
module win_delay_line #(
  parameter int DW       = 17,
  parameter int WIN_LOG2 = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [WIN_LOG2-1:0] wp,
  input  logic [DW-1:0]       din,
  output logic [DW-1:0]       dout
);

  // No reset: the fill counter in the parent masks stale entries.
  logic [DW-1:0] mem_q [2**WIN_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[wp] <= din;
  end

  assign dout = mem_q[wp];

endmodule

// File: rtl/moving_sum_win.sv
// rtl/moving_sum_win.sv - exact sliding sum of the last 2^WIN_LOG2 samples with average
module moving_sum_win
  import ofdm_rx_pkg::*;
#(
  parameter int DW        = 17,
  parameter int WIN_LOG2  = 4,
  parameter int SIGNED_IN = 0
) (
  input logic             clk,
  input logic             rst,
  moving_sum_win_if.slave bus
);

  localparam int SW = sum_width(DW, WIN_LOG2);
  localparam logic [WIN_LOG2:0]   FILL_MAX = (WIN_LOG2+1)'(2**WIN_LOG2);
  localparam logic [WIN_LOG2:0]   FILL_ONE = (WIN_LOG2+1)'(1);
  localparam logic [WIN_LOG2-1:0] WP_ONE   = WIN_LOG2'(1);

  if (WIN_LOG2 < WIN_LOG2_MIN || WIN_LOG2 > WIN_LOG2_MAX) begin : g_bad_win_log2
    $error("moving_sum_win: WIN_LOG2 out of range");
  end

  function automatic logic signed [SW-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED_IN != 0) return {{(SW-DW){v[DW-1]}}, v};
    return {{(SW-DW){1'b0}}, v};
  endfunction

  logic signed [SW-1:0] sum_q, sum_d, sum_base, old_ext;
  logic [WIN_LOG2:0]    fill_q, fill_d, fill_eff;
  logic [WIN_LOG2-1:0]  wp_q, wp_d, wp_eff;
  logic                 full_q, full_d;
  logic                 out_valid_q;
  logic [DW-1:0]        dl_dout;

  win_delay_line #(.DW(DW), .WIN_LOG2(WIN_LOG2)) u_dline (
    .clk  (clk),
    .we   (bus.in_valid),
    .wp   (wp_eff),
    .din  (bus.in_data),
    .dout (dl_dout)
  );

  // clr is folded in ahead of the update so clr+in_valid starts a fresh window.
  always_comb begin
    wp_eff   = bus.clr ? '0 : wp_q;
    fill_eff = bus.clr ? '0 : fill_q;
    sum_base = bus.clr ? '0 : sum_q;
    old_ext  = (fill_eff == FILL_MAX) ? ext(dl_dout) : '0;
    sum_d    = sum_base;
    fill_d   = fill_eff;
    wp_d     = wp_eff;
    if (bus.in_valid) begin
      sum_d  = sum_base + ext(bus.in_data) - old_ext;
      wp_d   = wp_eff + WP_ONE;
      fill_d = (fill_eff == FILL_MAX) ? FILL_MAX : fill_eff + FILL_ONE;
    end
    full_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      fill_q      <= '0;
      wp_q        <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      wp_q        <= wp_d;
      full_q      <= full_d;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.avg_out   = (DW+1)'(sum_q >>> WIN_LOG2);
  assign bus.full      = full_q;

endmodule
